// File: rtl/lopa16_rr_scheduler.sv
// Round-robin scheduler time-sharing one 16-bit lower-part-OR approximate adder.
// Optional build macro LOPA_CARRY_PRED_EN: predict the upper-part carry-in from the top lower bits.
module lopa16_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LOWER_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [16*N_REQ-1:0]    req_add1_i,
    input  logic [16*N_REQ-1:0]    req_add2_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [2:0]             resp_id_o,
    output logic [16:0]            resp_result_o,
    output logic [15:0]            ops_count_o
);

    localparam int UPPER_W = 16 - LOWER_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  last_ptr_q, last_ptr_d;
    logic [15:0] add1_q, add1_d;
    logic [15:0] add2_q, add2_d;
    logic [2:0]  resp_id_q, resp_id_d;
    logic [16:0] result_q, result_d;
    logic [15:0] ops_count_q, ops_count_d;

    logic             grant_found;
    logic [2:0]       grant_idx;
    logic [3:0]       cand;
    logic             hit;
    logic [N_REQ-1:0] grant_vec;
    logic [15:0]      sel_add1;
    logic [15:0]      sel_add2;

    logic             cin;
    logic [UPPER_W:0] upper_sum;
    logic [16:0]      approx_sum;

    // Circular search upward from last_ptr+1; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        hit         = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_ptr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            hit = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (cand == 4'(i)) begin
                    hit = req_valid_i[i];
                end
            end
            if (!grant_found && hit) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        sel_add1  = '0;
        sel_add2  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_found && (grant_idx == 3'(i))) begin
                grant_vec[i] = 1'b1;
                sel_add1     = req_add1_i[16*i +: 16];
                sel_add2     = req_add2_i[16*i +: 16];
            end
        end
    end

`ifdef LOPA_CARRY_PRED_EN
    assign cin = add1_q[LOWER_W-1] & add2_q[LOWER_W-1];
`else
    assign cin = 1'b0;
`endif

    // Upper part is an exact adder; the lower part is a plain bitwise OR.
    assign upper_sum  = {1'b0, add1_q[15:LOWER_W]} + {1'b0, add2_q[15:LOWER_W]}
                      + {{UPPER_W{1'b0}}, cin};
    assign approx_sum = {upper_sum, add1_q[LOWER_W-1:0] | add2_q[LOWER_W-1:0]};

    always_comb begin
        state_d     = state_q;
        last_ptr_d  = last_ptr_q;
        add1_d      = add1_q;
        add2_d      = add2_q;
        resp_id_d   = resp_id_q;
        result_d    = result_q;
        ops_count_d = ops_count_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    add1_d     = sel_add1;
                    add2_d     = sel_add2;
                    resp_id_d  = grant_idx;
                    last_ptr_d = grant_idx;
                    state_d    = ADD;
                end
            end
            ADD: begin
                result_d = approx_sum;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    ops_count_d = ops_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_ptr_q  <= 3'(N_REQ - 1);
            add1_q      <= '0;
            add2_q      <= '0;
            resp_id_q   <= '0;
            result_q    <= '0;
            ops_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_ptr_q  <= last_ptr_d;
            add1_q      <= add1_d;
            add2_q      <= add2_d;
            resp_id_q   <= resp_id_d;
            result_q    <= result_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE) ? grant_vec : '0;
    assign resp_valid_o  = (state_q == RESP);
    assign resp_id_o     = resp_id_q;
    assign resp_result_o = result_q;
    assign ops_count_o   = ops_count_q;

endmodule
